mux_arb_ctrl: RTL and testbench

Two-requester arbiter and sequencer for the shared 64-bit 2:1 datapath multiplexer. Requesters A and B present valid/ready/last beat streams. The block grants one owner at a time, drives the mux select, and passes the owner's handshake through to a single downstream consumer. Fairness is round-robin, and bursts are bounded.

---
 rtl/mux_arb_pkg.sv | 18 +
 rtl/mux_arb_ctrl_if.sv | 43 ++++
 rtl/mux_arb_ctrl_rr_pick2.sv | 27 ++
 rtl/mux_arb_ctrl.sv | 132 +++++++++++++
 tb/tb_mux_arb_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and constants for the mux_arb_ctrl slice.
//   state_e  : arbiter FSM states (IDLE, OWN_A, OWN_B)
//   SEL_A/B  : mux select encodings
//   STATS_W  : width of the optional grant statistics counters
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int unsigned STATS_W = 32;

endpackage

// File: rtl/mux_arb_ctrl_if.sv
// mux_arb_ctrl_if: handshake/data bundle between requesters A/B, the
// arbiter and the downstream consumer.
//   a_*/b_*  : requester valid/data/last in, ready out
//   o_*      : consumer valid/data out, ready in
//   sel/busy : mux select (0 = A, 1 = B) and ownership status
// Modports: slave = arbiter side, master = requester/consumer side.
interface mux_arb_ctrl_if #(
  parameter int unsigned WIDTH = 64
);

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             b_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_ready;
  logic             sel;
  logic             busy;

  modport slave (
    input  a_valid, a_data, a_last,
    input  b_valid, b_data, b_last,
    input  o_ready,
    output a_ready, b_ready,
    output o_valid, o_data,
    output sel, busy
  );

  modport master (
    output a_valid, a_data, a_last,
    output b_valid, b_data, b_last,
    output o_ready,
    input  a_ready, b_ready,
    input  o_valid, o_data,
    input  sel, busy
  );

endinterface

// File: rtl/mux_arb_ctrl_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   valid_a_i, valid_b_i : candidate requests
//   last_grant_i         : previous grantee (0 = A, 1 = B)
//   grant_valid_o        : at least one candidate is requesting
//   grant_id_o           : chosen candidate (0 = A, 1 = B)
module rr_pick2 (
  input  logic valid_a_i,
  input  logic valid_b_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  import mux_arb_pkg::*;

  always_comb begin
    grant_valid_o = valid_a_i | valid_b_i;
    if (valid_a_i && valid_b_i) begin
      grant_id_o = ~last_grant_i;
    end else if (valid_b_i) begin
      grant_id_o = SEL_B;
    end else begin
      grant_id_o = SEL_A;
    end
  end

endmodule

// File: rtl/mux_arb_ctrl.sv
// mux_arb_ctrl: round-robin arbiter/sequencer for a shared 2:1 data mux.
// Grants one of two valid/ready/last requesters, steers its handshake to
// the single consumer and bounds each grant to MAX_BURST beats.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : mux_arb_ctrl_if.slave (requester and consumer handshake)
//   grant_cnt_a/b : saturating grant counters, present only when the
//                   MUX_ARB_STATS_EN macro is defined
// The bus interface must be instantiated with the same WIDTH.
module mux_arb_ctrl
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  mux_arb_ctrl_if.slave       bus
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]  grant_cnt_a,
  output logic [STATS_W-1:0]  grant_cnt_b
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic sel_w, busy_w, own_valid, own_last;
  logic xfer, rel, grant_take;
  logic pick_a, pick_b, grant_valid, grant_id;

  // Output steering from the current owner.
  always_comb begin
    sel_w     = last_grant_q;
    busy_w    = 1'b0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    unique case (state_q)
      OWN_A: begin
        sel_w     = SEL_A;
        busy_w    = 1'b1;
        own_valid = bus.a_valid;
        own_last  = bus.a_last;
      end
      OWN_B: begin
        sel_w     = SEL_B;
        busy_w    = 1'b1;
        own_valid = bus.b_valid;
        own_last  = bus.b_last;
      end
      default: ;
    endcase
  end

  // Handshakes are masked during reset so no beat is accepted in the
  // cycle that reset is applied, even though the state is still OWN_x.
  assign bus.sel     = sel_w;
  assign bus.busy    = busy_w;
  assign bus.o_valid = own_valid & ~reset;
  assign bus.a_ready = (state_q == OWN_A) & bus.o_ready & ~reset;
  assign bus.b_ready = (state_q == OWN_B) & bus.o_ready & ~reset;
  assign bus.o_data  = sel_w ? bus.b_data : bus.a_data;

  assign xfer = bus.o_valid & bus.o_ready;
  assign rel  = xfer & (own_last | (beat_cnt_q == CNT_W'(MAX_BURST - 1)));

  // One picker serves both decisions: while owning, the owner's own
  // request is masked so only the other side can be chosen for handover.
  assign pick_a = (state_q == OWN_A) ? 1'b0 : bus.a_valid;
  assign pick_b = (state_q == OWN_B) ? 1'b0 : bus.b_valid;

  rr_pick2 u_pick (
    .valid_a_i     (pick_a),
    .valid_b_i     (pick_b),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  assign grant_take = grant_valid & ((state_q == IDLE) | rel);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    if (xfer) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
    if (rel) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end
    if (grant_take) begin
      state_d      = grant_id ? OWN_B : OWN_A;
      last_grant_d = grant_id;
      beat_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= SEL_B;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

`ifdef MUX_ARB_STATS_EN
  logic [STATS_W-1:0] grant_cnt_a_q, grant_cnt_b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt_a_q <= '0;
      grant_cnt_b_q <= '0;
    end else if (grant_take) begin
      if (!grant_id && (grant_cnt_a_q != '1)) grant_cnt_a_q <= grant_cnt_a_q + 1'b1;
      if (grant_id && (grant_cnt_b_q != '1))  grant_cnt_b_q <= grant_cnt_b_q + 1'b1;
    end
  end

  assign grant_cnt_a = grant_cnt_a_q;
  assign grant_cnt_b = grant_cnt_b_q;
`endif

endmodule

// File: tb/tb_mux_arb_ctrl.sv
module tb_mux_arb_ctrl;

  import mux_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mux_arb_ctrl_if #(.WIDTH(64)) if0 ();
  mux_arb_ctrl_if #(.WIDTH(64)) if1 ();

  // The MAX_BURST=1 instance sees exactly the same stimulus.
  assign if1.a_valid = if0.a_valid;
  assign if1.a_data  = if0.a_data;
  assign if1.a_last  = if0.a_last;
  assign if1.b_valid = if0.b_valid;
  assign if1.b_data  = if0.b_data;
  assign if1.b_last  = if0.b_last;
  assign if1.o_ready = if0.o_ready;

`ifdef MUX_ARB_STATS_EN
  logic [31:0] gca0, gcb0, gca1, gcb1;
`endif

  mux_arb_ctrl #(.WIDTH(64), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
`ifdef MUX_ARB_STATS_EN
    , .grant_cnt_a (gca0), .grant_cnt_b (gcb0)
`endif
  );

  mux_arb_ctrl #(.WIDTH(64), .MAX_BURST(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
`ifdef MUX_ARB_STATS_EN
    , .grant_cnt_a (gca1), .grant_cnt_b (gcb1)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if0.a_valid = 1'b0; if0.a_data = '0; if0.a_last = 1'b0;
    if0.b_valid = 1'b0; if0.b_data = '0; if0.b_last = 1'b0;
    if0.o_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    do_reset();

    // Reset state
    check("rst_sel",     64'(if0.sel),     64'd1);
    check("rst_busy",    64'(if0.busy),    64'd0);
    check("rst_ovalid",  64'(if0.o_valid), 64'd0);
    check("rst_aready",  64'(if0.a_ready), 64'd0);
    check("rst_bready",  64'(if0.b_ready), 64'd0);

    // Single requester A, one-beat burst
    if0.a_valid = 1'b1; if0.a_data = 64'd2048; if0.a_last = 1'b1; if0.o_ready = 1'b1;
    #1;
    check("single_idle_aready", 64'(if0.a_ready), 64'd0);
    tick();
    check("single_sel",    64'(if0.sel),     64'd0);
    check("single_busy",   64'(if0.busy),    64'd1);
    check("single_ovalid", 64'(if0.o_valid), 64'd1);
    check("single_odata",  if0.o_data,       64'd2048);
    check("single_aready", 64'(if0.a_ready), 64'd1);
    check("single_bready", 64'(if0.b_ready), 64'd0);
    tick();
    if0.a_valid = 1'b0;
    #1;
    check("single_rel_busy", 64'(if0.busy),    64'd0);
    check("single_rel_sel",  64'(if0.sel),     64'd0);
    check("single_rel_ov",   64'(if0.o_valid), 64'd0);

    // Tie after reset: A first, then zero-bubble handover to B
    do_reset();
    if0.a_valid = 1'b1; if0.a_data = 64'd2048; if0.a_last = 1'b1;
    if0.b_valid = 1'b1; if0.b_data = 64'd4096; if0.b_last = 1'b1;
    if0.o_ready = 1'b1;
    tick();
    check("tie_sel_a",   64'(if0.sel),     64'd0);
    check("tie_odata_a", if0.o_data,       64'd2048);
    check("tie_bready",  64'(if0.b_ready), 64'd0);
    tick();
    if0.a_valid = 1'b0;
    #1;
    check("tie_sel_b",    64'(if0.sel),     64'd1);
    check("tie_busy_b",   64'(if0.busy),    64'd1);
    check("tie_odata_b",  if0.o_data,       64'd4096);
    check("tie_bready_b", 64'(if0.b_ready), 64'd1);
    check("tie_aready_b", 64'(if0.a_ready), 64'd0);
    tick();
    if0.b_valid = 1'b0;
    #1;
    check("tie_end_busy", 64'(if0.busy), 64'd0);
    check("tie_end_sel",  64'(if0.sel),  64'd1);

    // Burst cap: both continuously valid, last=0
    do_reset();
    if0.a_valid = 1'b1; if0.a_data = 64'hAAAA; if0.a_last = 1'b0;
    if0.b_valid = 1'b1; if0.b_data = 64'hBBBB; if0.b_last = 1'b0;
    if0.o_ready = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      check($sformatf("cap4_sel_%0d", i), 64'(if0.sel), 64'(((i / 4) % 2) == 1));
      check($sformatf("cap4_ov_%0d", i),  64'(if0.o_valid), 64'd1);
      check($sformatf("cap1_sel_%0d", i), 64'(if1.sel), 64'(i % 2));
      check($sformatf("cap1_busy_%0d", i), 64'(if1.busy), 64'd1);
      tick();
    end

    // Backpressure: counter must not advance while o_ready is low
    do_reset();
    if0.a_valid = 1'b1; if0.a_data = 64'h1234; if0.a_last = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_aready_%0d", i), 64'(if0.a_ready), 64'd0);
      check($sformatf("bp_busy_%0d", i),   64'(if0.busy),    64'd1);
      check($sformatf("bp_sel_%0d", i),    64'(if0.sel),     64'd0);
      tick();
    end
    if0.o_ready = 1'b1;
    #1;
    check("bp_release_aready", 64'(if0.a_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_beat_busy_%0d", i + 1), 64'(if0.busy), 64'd1);
    end
    tick();
    check("bp_after4_busy",   64'(if0.busy),    64'd0);
    check("bp_after4_ovalid", 64'(if0.o_valid), 64'd0);
    if0.a_valid = 1'b0;

    // Reset mid-burst with both requesting
    do_reset();
    if0.a_valid = 1'b1; if0.a_last = 1'b0;
    if0.b_valid = 1'b1; if0.b_last = 1'b0;
    if0.o_ready = 1'b1;
    tick();
    tick();
    check("mid_pre_sel", 64'(if0.sel), 64'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_aready", 64'(if0.a_ready), 64'd0);
    check("mid_rst_ovalid", 64'(if0.o_valid), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_post_sel",    64'(if0.sel),     64'd1);
    check("mid_post_busy",   64'(if0.busy),    64'd0);
    check("mid_post_aready", 64'(if0.a_ready), 64'd0);
    check("mid_post_bready", 64'(if0.b_ready), 64'd0);
    tick();
    check("mid_regrant_sel",  64'(if0.sel),  64'd0);
    check("mid_regrant_busy", 64'(if0.busy), 64'd1);

`ifdef MUX_ARB_STATS_EN
    // Grants A,B,A,B,A on single-beat bursts
    do_reset();
    check("stats_rst_a", 64'(gca0), 64'd0);
    check("stats_rst_b", 64'(gcb0), 64'd0);
    if0.a_valid = 1'b1; if0.a_last = 1'b1;
    if0.b_valid = 1'b1; if0.b_last = 1'b1;
    if0.o_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    clear_inputs();
    #1;
    check("stats_a", 64'(gca0), 64'd3);
    check("stats_b", 64'(gcb0), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
